serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Framed serial receiver that sits directly downstream of the SISO shift register and consumes its `sout` bit stream, one bit per clock. It detects a start bit, deserialises a fixed-width LSB-first data word, checks even parity and the stop bit, and presents the word on a parallel valid/ready port. It drives the parallel side of the serial path and reports parity, framing and overrun errors.

## Interface
- `WIDTH`, default 8: data bits per frame (min 2).
- `clk` input, 1 bit: rising-edge clock; one serial bit is sampled per edge.
- `rst` input, 1 bit: asynchronous, active-high reset; clears all state immediately.
- `sin` input, 1 bit: serial line, driven by the SISO `sout`; idle level is 0.
- `dout` output, WIDTH bits: received word, valid while `dout_valid`=1; resets to 0.
- `dout_valid` output, 1 bit: word available; resets to 0.
- `dout_ready` input, 1 bit: consumer accepts the word on an edge where `dout_valid && dout_ready`.
- `parity_err` output, 1 bit: one-cycle pulse; resets to 0.
- `frame_err` output, 1 bit: one-cycle pulse; resets to 0.
- `overrun` output, 1 bit: one-cycle pulse; resets to 0.

## Operation
- The frame is: start bit (1), then WIDTH data bits LSB first, then an even-parity bit (XOR of the data bits), then a stop bit (0).
- FSM states:
  - IDLE: `sin`=1 moves to DATA; otherwise stay.
  - DATA: shift the sampled bit into the shift register and increment the bit counter; after WIDTH bits, move to PARITY.
  - PARITY: latch the sampled bit; move to STOP.
  - STOP: evaluate the frame; always return to IDLE.
- STOP evaluation, in priority order:
  - Stop bit = 1: pulse `frame_err`; discard the word. The offending bit is not treated as a new start bit.
  - Parity mismatch: pulse `parity_err`; discard the word.
  - Otherwise, the word is good:
    - If the holding register is free, or is being accepted on this same edge (`dout_valid && dout_ready`): load `dout` and set `dout_valid`=1.
    - Otherwise: pulse `overrun`, drop the new word, and leave `dout` unchanged.
- `dout_valid` clears on an accept edge, unless a new word loads on that same edge, in which case it stays 1 with the new data.
- `dout` is stable while `dout_valid`=1 and not accepted.
- Error pulses are mutually exclusive per frame and last exactly one cycle.
- Reset asserted mid-frame aborts the frame: the partial word is lost, all outputs return to their reset values, and the FSM is in IDLE on reset release.

## Timing
- A frame occupies WIDTH+3 edges, and frames may be back-to-back: the start bit can be sampled on the edge immediately after the STOP edge.
- The output updates on the STOP edge: `dout`/`dout_valid` or the error pulse are visible in the cycle after the stop bit is sampled, so latency from the last data bit is 2 edges.
- The bit counter is ceil(log2(WIDTH+1)) bits wide, saturates at no point, and is cleared on entry to DATA.
- `dout_ready` is not required to be stable; it is sampled only on edges.

## Structure
- Shared package `serial_frame_pkg` holds:
  - the state encoding constants IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3;
  - the frame polarity constants START_BIT=1 and STOP_BIT=0.
- One sub-module: `sipo_shreg` (WIDTH-bit serial-in parallel-out, shift-enable, asynchronous `rst`). This sub-module is reused by other parallel-output stages.
- The parity accumulator, FSM, and output holding register live in the top module.

## Test plan
- Good frame, WIDTH=8, data 0xA5 (sin sequence 1,1,0,1,0,0,1,0,1,0,0), `dout_ready`=1 → `dout`=0xA5 and `dout_valid` high for 1 cycle after the 11th edge; no error pulses.
- Same frame with the parity bit forced to 1 → `parity_err` pulses for 1 cycle; `dout_valid` stays 0.
- 0x3C frame with stop bit 1 → `frame_err` pulses for 1 cycle; a correct 0x3C frame on the next edges is still received.
- Two back-to-back frames 0xA5 then 0x3C with `dout_ready`=0 → `dout` holds 0xA5; `overrun` pulses at the end of the second frame; raising `dout_ready` clears `dout_valid` on the next edge.
- Holding register full with 0xA5, and `dout_ready` asserted on the exact STOP edge of frame 0x3C → no overrun; `dout`=0x3C and `dout_valid` stays 1.
- `rst` asserted asynchronously after 4 data bits → all outputs 0 immediately; a following full frame 0x0F → `dout`=0x0F.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the framed serial receive path:
// FSM state encoding and serial-line frame polarity.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/sipo_shreg.sv
// Serial-in parallel-out shift register; LSB-first, so new bits enter at the MSB
// and the first bit received ends up in bit 0 after WIDTH shifts.
module sipo_shreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits LSB first, even parity, stop bit,
// delivered on a valid/ready port with parity, framing and overrun error pulses.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             pbit_q, pbit_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;
    logic             shift_en;
    logic             accept;
    logic [WIDTH-1:0] word;

    sipo_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk (clk),
        .rst (rst),
        .en  (shift_en),
        .sin (sin),
        .q   (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            pbit_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            pbit_q  <= pbit_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        pbit_d   = pbit_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        shift_en = 1'b0;

        accept = valid_q && dout_ready;
        if (accept) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (sin == START_BIT) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            DATA: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                par_d    = par_q ^ sin;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                pbit_d  = sin;
                state_d = STOP;
            end
            STOP: begin
                // A bad stop bit is not reused as a start bit: always back to IDLE.
                state_d = IDLE;
                if (sin != STOP_BIT) begin
                    ferr_d = 1'b1;
                end else if (pbit_q != par_q) begin
                    perr_d = 1'b1;
                end else if (!valid_q || accept) begin
                    dout_d  = word;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized self-checking bench for serial_frame_rx against a frame-level reference model.
module tb_serial_frame_rx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: holding register plus the pulses expected after the last edge.
    logic [W-1:0] m_data  = '0;
    logic         m_valid = 1'b0;
    logic         e_pe = 1'b0, e_fe = 1'b0, e_ov = 1'b0;

    serial_frame_rx #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string when);
        check({when, ":dout_valid"}, 32'(dout_valid), 32'(m_valid));
        check({when, ":dout"}, 32'(dout), 32'(m_data));
        check({when, ":parity_err"}, 32'(parity_err), 32'(e_pe));
        check({when, ":frame_err"}, 32'(frame_err), 32'(e_fe));
        check({when, ":overrun"}, 32'(overrun), 32'(e_ov));
    endtask

    function automatic logic even_par(input logic [W-1:0] d);
        return ^d;
    endfunction

    // rmode: 0 never ready, 1 always ready, 2 random, 3 ready only on the stop edge
    function automatic logic pick_ready(input int rmode, input logic last);
        case (rmode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(0, 1));
            default: return last;
        endcase
    endfunction

    // One clock: drive at negedge, model the edge, compare 1 time unit later.
    task automatic step(input logic s, input logic r, input logic is_stop,
                        input logic [W-1:0] fd, input logic fp, input logic fs);
        logic acc, load;
        sin        = s;
        dout_ready = r;
        @(posedge clk);
        acc  = m_valid && r;
        load = 1'b0;
        e_pe = 1'b0;
        e_fe = 1'b0;
        e_ov = 1'b0;
        if (is_stop) begin
            if (fs)                      e_fe = 1'b1;
            else if (fp != even_par(fd)) e_pe = 1'b1;
            else if (!m_valid || acc)    load = 1'b1;
            else                         e_ov = 1'b1;
        end
        if (load) begin
            m_data  = fd;
            m_valid = 1'b1;
        end else if (acc) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs(is_stop ? "stop" : "bit");
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic p, input logic s,
                              input int rmode);
        logic [W+2:0] bits;
        bits = {s, p, d, 1'b1};
        for (int i = 0; i < W + 3; i++) begin
            step(bits[i], pick_ready(rmode, i == W + 2), i == W + 2, d, p, s);
        end
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            step(1'b0, pick_ready(rmode, 1'b0), 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        logic         p, s;

        rst        = 1'b1;
        sin        = 1'b0;
        dout_ready = 1'b0;
        #12;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Good 0xA5 frame, consumer always ready
        d = 8'hA5;
        send_frame(d, even_par(d), 1'b0, 1);
        idle(2, 1);

        // Parity bit forced to 1
        send_frame(d, 1'b1, 1'b0, 1);
        idle(1, 1);

        // 0x3C with bad stop bit, then a correct 0x3C right after
        d = 8'h3C;
        send_frame(d, even_par(d), 1'b1, 1);
        send_frame(d, even_par(d), 1'b0, 1);
        idle(2, 1);

        // Back-to-back with no consumer: second frame overruns
        d = 8'hA5;
        send_frame(d, even_par(d), 1'b0, 0);
        d = 8'h3C;
        send_frame(d, even_par(d), 1'b0, 0);
        idle(1, 1);
        idle(1, 0);

        // Accept on the exact stop edge of the next frame: no overrun
        d = 8'hA5;
        send_frame(d, even_par(d), 1'b0, 0);
        d = 8'h3C;
        send_frame(d, even_par(d), 1'b0, 3);
        idle(1, 0);
        idle(1, 1);

        // Async reset after 4 data bits with a word held
        d = 8'hA5;
        send_frame(d, even_par(d), 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        m_data  = '0;
        m_valid = 1'b0;
        e_pe    = 1'b0;
        e_fe    = 1'b0;
        e_ov    = 1'b0;
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        d = 8'h0F;
        send_frame(d, even_par(d), 1'b0, 0);
        idle(1, 1);

        // Random frames, gaps and ready
        for (int f = 0; f < 300; f++) begin
            d = W'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~even_par(d) : even_par(d);
            s = ($urandom_range(0, 7) == 0);
            send_frame(d, p, s, 2);
            idle($urandom_range(0, 2), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
